rand_range_sampler: RTL and testbench
=====================================

Name: rand_range_sampler

Overview:
- Consumer stage for the free-running 32-bit LFSR word.
- Converts each pseudo-random word into a uniformly distributed integer in [0, limit) using mask-and-reject sampling.
- Buffers accepted samples in a small FIFO.
- Delivers them to downstream logic over a valid/ready handshake.

Parameters:
- OUT_W, 8, width of output sample and of limit; legal 1..16
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  input  1  rising-edge clock, same clock as the LFSR
- reset  input  1  asynchronous, active-high reset
- rand_in  input  32  LFSR register value; treated as a new random word every cycle
- cfg_load  input  1  one-cycle pulse: capture limit, flush FIFO
- limit  input  OUT_W  exclusive upper bound; 0 means full range 2^OUT_W
- out_data  output  OUT_W  sample at FIFO head
- out_valid  output  1  FIFO not empty
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready
- busy  output  1  high in RUN state

Behaviour:
- Reset, asynchronous and active-high, clears all state:
  - state=IDLE, FIFO empty, out_valid=0, out_data=0, busy=0.
  - Latched limit register=0, mask register=0.
- Sample source: cand = rand_in[31:32-OUT_W] (top OUT_W bits).
- Mask: the smallest all-ones value >= limit-1.
  - limit=0: mask = all ones; every candidate is accepted.
  - limit=1: mask = 0; every sample is 0.
  - Mask is computed at cfg_load and registered with limit; it is not recomputed per cycle.
- Accept rule: m = cand & mask; accepted iff limit_reg==0 or m < limit_reg. A rejected word is dropped.
- Rejection rate is below 50% for any limit.
- FSM:
  - IDLE: no writes. cfg_load -> FLUSH.
  - FLUSH: one cycle; FIFO pointers and count cleared; limit_reg and mask_reg valid. -> RUN.
  - RUN: each cycle, an accepted sample is written if the FIFO is not full or a read occurs in the same cycle. cfg_load -> FLUSH.
- cfg_load in any state restarts through FLUSH:
  - In-flight FIFO contents are discarded.
  - out_valid drops the cycle after cfg_load.
- Latency: rand_in sampled at edge N (in RUN) appears on out_data with out_valid=1 after edge N when the FIFO was empty. out_data is registered FIFO head; no combinational path from rand_in.
- FIFO full: accepted samples are dropped silently; no backpressure to the LFSR.
- Full with a simultaneous read: the write proceeds and count is unchanged.
- Empty: out_ready is ignored.
- Simultaneous read and write on an empty FIFO is impossible, since out_valid is 0.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- out_data and out_valid hold stable while out_valid && !out_ready.
- busy = (state==RUN).

Optional Feature:
- Macro RAND_STATS_EN.
- With the macro defined, two additional 16-bit outputs are present:
  - rej_count: saturating count of rejected words in RUN.
  - drop_count: saturating count of accepted-but-dropped words due to full FIFO.
  - Both counters clear on reset and in FLUSH, and saturate at 16'hFFFF.
- Without the macro: the ports and counters do not exist; the core behaviour is identical.

Decomposition:
- Package rand_pkg holds:
  - FSM state encodings IDLE=2'd0, FLUSH=2'd1, RUN=2'd2.
  - Default OUT_W and DEPTH constants.
  - Statistics counter width of 16.
- One sub-module: rand_fifo, a synchronous FIFO (DEPTH, OUT_W) with wr_en, rd_en, flush, full, empty, head data.
- Sampling, mask logic and FSM stay in the top module.

Test Plan:
- Reset mid-RUN with FIFO holding 3 entries -> out_valid=0, busy=0, out_data=0 immediately (async); no writes until the next cfg_load.
- OUT_W=8, cfg_load with limit=10 (mask=0x0F), rand_in = 0x05xxxxxx then 0x0Axxxxxx then 0x1Fxxxxxx, out_ready=1 -> outputs 5 only; 0x0A and 0x0F (masked) are rejected.
- limit=0, rand_in = 0xFFxxxxxx, 0x00xxxxxx -> outputs 0xFF then 0x00; no rejections. limit=1, any input -> outputs always 0.
- out_ready=0, 6 accepted words, DEPTH=4 -> FIFO holds the first 4 in order; words 5 and 6 are dropped (drop_count=2 with RAND_STATS_EN). out_ready=1 then drains exactly 4 values in order.
- FIFO full with out_ready=1 and an accepted word in the same cycle -> one read and one write; count stays 4, order preserved.
- cfg_load while out_valid=1 with 2 entries -> out_valid=0 next cycle. After FLUSH, only samples under the new limit appear; none of the old entries are emitted.

Source files
------------

// File: rtl/rand_pkg.sv
// Purpose : shared FSM encodings, default sizes and mask helper for rand_range_sampler.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int DEF_OUT_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int STAT_W    = 16;

  // Smears the highest set bit downward, giving the smallest all-ones
  // value that is >= v. Sixteen bits covers the widest legal OUT_W.
  function automatic logic [15:0] smear_ones(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    r = r | (r >> 1);
    r = r | (r >> 2);
    r = r | (r >> 4);
    r = r | (r >> 8);
    return r;
  endfunction

endpackage

// File: rtl/rand_fifo.sv
// Purpose : synchronous FIFO holding accepted samples; head is read straight from storage.
// Latency : a write at edge N is visible at head after edge N when empty.
// Backpr. : writes while full are dropped unless a read happens in the same cycle.
// Ports   : clk, reset (async, active-high), flush, wr_en/wr_data, rd_en,
//           head (entry at read pointer), full, empty.
module rand_fifo
  import rand_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [OUT_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // When full, a same-cycle read frees the slot the write lands in
  // (wr_ptr == rd_ptr), so the pair is legal and count stays put.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rand_range_sampler.sv
// Purpose : maps each LFSR word to a uniform integer in [0, limit) by mask-and-reject, buffered in a FIFO.
// Latency : word sampled at edge N in RUN is on out_data/out_valid after edge N if the FIFO was empty.
// Backpr. : out_ready drains the FIFO; when full, accepted words are dropped (the LFSR is never stalled).
// Ports   : clk, reset (async, active-high), rand_in[31:0], cfg_load, limit,
//           out_data/out_valid/out_ready, busy.
// Option  : RAND_STATS_EN adds rej_count and drop_count (16-bit, saturating).
module rand_range_sampler
  import rand_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      rand_in,
  input  logic             cfg_load,
  input  logic [OUT_W-1:0] limit,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef RAND_STATS_EN
  ,
  output logic [STAT_W-1:0] rej_count,
  output logic [STAT_W-1:0] drop_count
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [OUT_W-1:0] limit_reg;
  logic [OUT_W-1:0] mask_reg;
  logic [OUT_W-1:0] mask_new;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] masked;
  logic             accept;
  logic             wr_en;
  logic             rd_en;
  logic             flush;
  logic             full;
  logic             empty;
  logic             unused_rand_bits;

  assign cand             = rand_in[31 -: OUT_W];
  assign unused_rand_bits = ^rand_in[31-OUT_W:0];

  // limit==0 means the full 2^OUT_W range; otherwise round limit-1 up to
  // an all-ones mask so fewer than half of the masked values are rejected.
  assign mask_new = (limit == '0) ? '1
                                  : OUT_W'(smear_ones(16'(limit - 1'b1)));

  assign masked = cand & mask_reg;
  assign accept = (limit_reg == '0) || (masked < limit_reg);

  // Flushing on the cfg_load edge itself (not only in FLUSH) makes
  // out_valid fall in the cycle right after the pulse.
  assign flush = cfg_load || (state == FLUSH);
  assign wr_en = (state == RUN) && !cfg_load && accept;
  assign rd_en = out_ready && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      limit_reg <= '0;
      mask_reg  <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_load) begin
        limit_reg <= limit;
        mask_reg  <= mask_new;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:    if (cfg_load) state_nxt = FLUSH;
      FLUSH:   state_nxt = cfg_load ? FLUSH : RUN;
      RUN: begin
        busy = 1'b1;
        if (cfg_load) state_nxt = FLUSH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  rand_fifo #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (masked),
    .rd_en   (rd_en),
    .head    (out_data),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;

`ifdef RAND_STATS_EN
  logic rej_evt;
  logic drop_evt;

  assign rej_evt  = (state == RUN) && !cfg_load && !accept;
  assign drop_evt = wr_en && full && !rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rej_count  <= '0;
      drop_count <= '0;
    end else if (state == FLUSH) begin
      rej_count  <= '0;
      drop_count <= '0;
    end else begin
      if (rej_evt && (rej_count != '1))   rej_count  <= rej_count + 1'b1;
      if (drop_evt && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rand_range_sampler.sv
module tb_rand_range_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rand_in;
  logic        cfg_load;
  logic [7:0]  limit;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef RAND_STATS_EN
  logic [15:0] rej_count;
  logic [15:0] drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rand_range_sampler #(.OUT_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rand_in   (rand_in),
    .cfg_load  (cfg_load),
    .limit     (limit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef RAND_STATS_EN
    ,
    .rej_count (rej_count),
    .drop_count(drop_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues cfg_load for one cycle, then waits out FLUSH so RUN starts next.
  task automatic configure(input logic [7:0] lim, input logic [31:0] idle_word);
    cfg_load = 1'b1;
    limit    = lim;
    rand_in  = idle_word;
    step();
    cfg_load = 1'b0;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    rand_in   = 32'h0C00_0000;
    cfg_load  = 1'b0;
    limit     = 8'd0;
    out_ready = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy",  busy,      0);
    check("rst_data",  out_data,  0);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    check("idle_no_write", out_valid, 0);
    check("idle_busy",     busy,      0);

    // limit=10 -> mask 0x0F; 0x05 accepted, 0x0A and 0x1F&0x0F=0x0F rejected
    cfg_load = 1'b1; limit = 8'd10; rand_in = 32'h0500_0000;
    step();
    check("flush_busy", busy, 0);
    cfg_load = 1'b0;
    step();
    check("run_busy",        busy,      1);
    check("flush_no_write",  out_valid, 0);
    out_ready = 1'b1;
    rand_in = 32'h0512_3456; step();
    check("l10_valid", out_valid, 1);
    check("l10_data",  out_data,  8'h05);
    rand_in = 32'h0A00_0001; step();
    check("l10_rej_0A", out_valid, 0);
    rand_in = 32'h1FFF_FFFF; step();
    check("l10_rej_1F", out_valid, 0);

    // limit=0: full range, nothing rejected
    configure(8'd0, 32'hFF00_0000);
    rand_in = 32'hFF12_3456; step();
    check("l0_ff_valid", out_valid, 1);
    check("l0_ff_data",  out_data,  8'hFF);
    rand_in = 32'h0000_00FF; step();
    check("l0_00_valid", out_valid, 1);
    check("l0_00_data",  out_data,  8'h00);

    // limit=1: every sample is 0; cfg_load also drops out_valid next cycle
    cfg_load = 1'b1; limit = 8'd1; rand_in = 32'hAB00_0000;
    step();
    check("l1_cfg_drop", out_valid, 0);
    cfg_load = 1'b0;
    step();
    rand_in = 32'hAB00_0000; step();
    check("l1_valid_a", out_valid, 1);
    check("l1_data_a",  out_data,  0);
    rand_in = 32'h7700_0000; step();
    check("l1_data_b",  out_data,  0);

    // limit=12 (mask 0x0F), 6 accepted words into DEPTH=4 with no reads
    out_ready = 1'b0;
    configure(8'd12, 32'h0E00_0000);
    rand_in = 32'h3100_0000; step();
    rand_in = 32'h0200_0000; step();
    rand_in = 32'h0300_0000; step();
    rand_in = 32'h0400_0000; step();
    rand_in = 32'h0500_0000; step();
    rand_in = 32'h0600_0000; step();
    rand_in = 32'h0E00_0000;
    check("full_head", out_data, 8'h01);
`ifdef RAND_STATS_EN
    check("drop_count", drop_count, 2);
`endif
    step();
    check("hold_data",  out_data,  8'h01);
    check("hold_valid", out_valid, 1);
    out_ready = 1'b1;
    step(); check("drain_2", out_data, 8'h02);
    step(); check("drain_3", out_data, 8'h03);
    step(); check("drain_4", out_data, 8'h04);
    step(); check("drain_empty", out_valid, 0);

    // full FIFO with a simultaneous read and accepted write
    out_ready = 1'b0;
    rand_in = 32'h0100_0000; step();
    rand_in = 32'h0200_0000; step();
    rand_in = 32'h0300_0000; step();
    rand_in = 32'h0400_0000; step();
    out_ready = 1'b1;
    rand_in = 32'h0900_0000; step();
    rand_in = 32'h0E00_0000;
    check("rw_head_2", out_data, 8'h02);
    step(); check("rw_head_3", out_data, 8'h03);
    step(); check("rw_head_4", out_data, 8'h04);
    step(); check("rw_head_9", out_data, 8'h09);
    step(); check("rw_empty",  out_valid, 0);

    // cfg_load with 2 entries buffered: old entries never emerge
    out_ready = 1'b0;
    rand_in = 32'h0500_0000; step();
    rand_in = 32'h0600_0000; step();
    check("pre_cfg_head", out_data, 8'h05);
    cfg_load = 1'b1; limit = 8'd3; rand_in = 32'h0700_0000;
    step();
    check("cfg_drop_valid", out_valid, 0);
    cfg_load = 1'b0;
    step();
    check("post_flush_valid", out_valid, 0);
    rand_in = 32'h0700_0000; step();
    check("l3_rej_3", out_valid, 0);
    rand_in = 32'h0600_0000; step();
    check("l3_valid", out_valid, 1);
    check("l3_data",  out_data,  8'h02);

    // async reset with 3 entries buffered
    rand_in = 32'h0100_0000; step();
    step();
    rand_in = 32'h0700_0000;
    check("pre_rst_head", out_data, 8'h02);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy",  busy,      0);
    check("arst_data",  out_data,  0);
    step();
    reset = 1'b0;
    rand_in = 32'h0100_0000;
    step();
    step();
    step();
    check("post_rst_no_write", out_valid, 0);
    check("post_rst_busy",     busy,      0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
